// File: rtl/cpu_mc.sv
// cpu_mc: multicycle Hack-style CPU with FETCH/READ/EXEC/WRITE/HALT sequencing,
// held memory requests with wait-state handshake and a sticky timeout fault.
module cpu_mc #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              inst_valid_i,
    input  logic [DATA_W-1:0] in_m_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] out_m_o,
    output logic              write_m_o,
    output logic              read_m_o,
    output logic [ADDR_W-1:0] address_m_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fault_o
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    typedef enum logic [2:0] {FETCH, READ, EXEC, WRITE, HALT} state_t;
    state_t            state_q;
    logic [DATA_W-1:0] a_q, d_q, ir_q, mr_q, out_m_q;
    logic [ADDR_W-1:0] addr_q, pc_q, pc_d;
    logic              write_q, read_q, fault_q;
    logic [WW-1:0]     wait_q;
    logic [DATA_W-1:0] x_z, x_op, y_sel, y_z, y_op, sum_d, alu_d;
    logic              zr, ng, jmp, timeout;
    always_comb begin
        x_z     = ir_q[11] ? '0 : d_q;
        x_op    = ir_q[10] ? ~x_z : x_z;
        y_sel   = ir_q[12] ? mr_q : a_q;
        y_z     = ir_q[9] ? '0 : y_sel;
        y_op    = ir_q[8] ? ~y_z : y_z;
        sum_d   = ir_q[7] ? x_op + y_op : x_op & y_op;
        alu_d   = ir_q[6] ? ~sum_d : sum_d;
        zr      = alu_d == '0;
        ng      = alu_d[DATA_W-1];
        jmp     = ir_q[DATA_W-1] & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr));
        // Jumps target the A value held before this instruction, even if it also loads A.
        pc_d    = jmp ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        timeout = !mem_ack_i && (wait_q == WW'(MAX_WAIT - 1));
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FETCH;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mr_q    <= '0;
            out_m_q <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                FETCH: if (inst_valid_i) begin
                    ir_q <= inst_i;
                    if (inst_i[DATA_W-1] && inst_i[12]) begin
                        read_q  <= 1'b1;
                        addr_q  <= a_q[ADDR_W-1:0];
                        state_q <= READ;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                READ: if (mem_ack_i) begin
                    mr_q    <= in_m_i;
                    read_q  <= 1'b0;
                    wait_q  <= '0;
                    state_q <= EXEC;
                end else if (timeout) begin
                    read_q  <= 1'b0;
                    fault_q <= 1'b1;
                    state_q <= HALT;
                end else begin
                    wait_q <= wait_q + WW'(1);
                end
                EXEC: begin
                    pc_q <= pc_d;
                    if (!ir_q[DATA_W-1]) begin
                        a_q     <= {1'b0, ir_q[DATA_W-2:0]};
                        state_q <= FETCH;
                    end else begin
                        if (ir_q[5]) a_q <= alu_d;
                        if (ir_q[4]) d_q <= alu_d;
                        if (ir_q[3]) begin
                            out_m_q <= alu_d;
                            addr_q  <= a_q[ADDR_W-1:0];
                            write_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                WRITE: if (mem_ack_i) begin
                    write_q <= 1'b0;
                    wait_q  <= '0;
                    state_q <= FETCH;
                end else if (timeout) begin
                    write_q <= 1'b0;
                    fault_q <= 1'b1;
                    state_q <= HALT;
                end else begin
                    wait_q <= wait_q + WW'(1);
                end
                HALT: state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end
    assign out_m_o     = out_m_q;
    assign write_m_o   = write_q;
    assign read_m_o    = read_q;
    assign address_m_o = addr_q;
    assign pc_o        = pc_q;
    assign fault_o     = fault_q;
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: drives a 16-bit and a 24-bit cpu_mc against an instruction-level reference model.
module tb_cpu_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b1, sel = 1'b0, inst_valid = 1'b0, mem_ack = 1'b0;
    logic [23:0] inst = '0, in_m = '0;
    logic [15:0] out16;
    logic [14:0] a16, pc16;
    logic        w16, r16, f16;
    logic [23:0] out24;
    logic [19:0] a24, pc24;
    logic        w24, r24, f24;
    logic        o_read, o_write, o_fault;
    logic [19:0] o_addr, o_pc;
    logic [23:0] o_data;
    int          n_checks = 0, n_errors = 0;
    logic [23:0] ref_a, ref_d;
    logic [19:0] ref_pc;
    logic [23:0] mem [int];
    int          last_rc, last_wc;
    logic [19:0] last_waddr;
    logic [23:0] last_wdata;

    cpu_mc dut16 (
        .clk_i(clk), .reset_i(reset), .inst_i(inst[15:0]), .inst_valid_i(inst_valid & !sel),
        .in_m_i(in_m[15:0]), .mem_ack_i(mem_ack & !sel), .out_m_o(out16), .write_m_o(w16),
        .read_m_o(r16), .address_m_o(a16), .pc_o(pc16), .fault_o(f16)
    );
    cpu_mc #(.DATA_W(24), .ADDR_W(20)) dut24 (
        .clk_i(clk), .reset_i(reset), .inst_i(inst), .inst_valid_i(inst_valid & sel),
        .in_m_i(in_m), .mem_ack_i(mem_ack & sel), .out_m_o(out24), .write_m_o(w24),
        .read_m_o(r24), .address_m_o(a24), .pc_o(pc24), .fault_o(f24)
    );
    assign o_read  = sel ? r24 : r16;
    assign o_write = sel ? w24 : w16;
    assign o_fault = sel ? f24 : f16;
    assign o_addr  = sel ? a24 : {5'd0, a16};
    assign o_pc    = sel ? pc24 : {5'd0, pc16};
    assign o_data  = sel ? out24 : {8'd0, out16};

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; inst_valid = 1'b0; mem_ack = 1'b0; inst = '0; in_m = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        ref_a = '0; ref_d = '0; ref_pc = '0;
    endtask

    // Executes one instruction; the model decides the expected latency, requests and results.
    task automatic run_inst(input logic [23:0] ins_in, input int rwait, input int wwait, input bit noise);
        int          w = sel ? 24 : 16;
        logic [23:0] mask = sel ? 24'hFFFFFF : 24'h00FFFF;
        logic [19:0] amask = sel ? 20'hFFFFF : 20'h07FFF;
        logic [23:0] ins, x, y, res, rdata;
        logic [19:0] addr, exp_pc;
        bit          is_c, rd, wr, zr, ng, jmp;
        int          lat, rc, wc;
        ins = ins_in & mask;
        is_c = ins[w-1];
        addr = ref_a[19:0] & amask;
        rd = is_c && ins[12];
        wr = is_c && ins[3];
        if (mem.exists(int'(addr))) rdata = mem[int'(addr)];
        else begin
            rdata = 24'($urandom) & mask;
            mem[int'(addr)] = rdata;
        end
        x = ins[11] ? 24'd0 : ref_d;
        if (ins[10]) x = ~x & mask;
        y = ins[12] ? rdata : ref_a;
        if (ins[9]) y = 24'd0;
        if (ins[8]) y = ~y & mask;
        res = ins[7] ? ((x + y) & mask) : (x & y);
        if (ins[6]) res = ~res & mask;
        zr = (res == 24'd0);
        ng = res[w-1];
        jmp = is_c && ((ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr));
        exp_pc = jmp ? addr : ((ref_pc + 20'd1) & amask);
        lat = 2 + (rd ? rwait + 1 : 0) + (wr ? wwait + 1 : 0);
        rc = 0; wc = 0;
        inst = ins; inst_valid = 1'b1;
        mem_ack = noise ? 1'($urandom) : 1'b0;
        for (int c = 0; c < lat; c++) begin
            @(posedge clk); @(negedge clk);
            inst_valid = 1'b0;
            mem_ack = noise ? 1'($urandom) : 1'b0;
            n_checks++;
            if (o_read && o_write) begin
                n_errors++; $display("FAIL both_req: readM and writeM both high at cycle %0d", c);
            end
            if (o_read) begin
                rc++;
                n_checks++;
                if (o_addr !== addr) begin
                    n_errors++; $display("FAIL read_addr: got %h want %h", o_addr, addr);
                end
                mem_ack = (rc > rwait);
                in_m = mem_ack ? rdata : 24'($urandom);
            end
            if (o_write) begin
                wc++;
                n_checks++;
                if (o_addr !== addr || o_data !== res || o_pc !== exp_pc) begin
                    n_errors++;
                    $display("FAIL write_req: addr %h data %h pc %h want %h %h %h", o_addr, o_data, o_pc, addr, res, exp_pc);
                end
                last_waddr = o_addr; last_wdata = o_data;
                mem_ack = (wc > wwait);
            end
        end
        mem_ack = 1'b0;
        n_checks++;
        if (o_pc !== exp_pc) begin
            n_errors++; $display("FAIL pc: inst %h got %h want %h", ins, o_pc, exp_pc);
        end
        n_checks++;
        if (rc !== (rd ? rwait + 1 : 0) || wc !== (wr ? wwait + 1 : 0) || o_read || o_write) begin
            n_errors++;
            $display("FAIL req_cycles: inst %h read %0d write %0d want %0d %0d", ins, rc, wc, rd ? rwait + 1 : 0, wr ? wwait + 1 : 0);
        end
        last_rc = rc; last_wc = wc;
        if (!is_c) ref_a = ins & (mask >> 1);
        else begin
            if (ins[5]) ref_a = res;
            if (ins[4]) ref_d = res;
            if (wr) mem[int'(addr)] = res;
        end
        ref_pc = exp_pc;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            do_reset();
            n_checks++;
            if (o_pc !== 20'd0 || o_read || o_write || o_fault || o_addr !== 20'd0 || o_data !== 24'd0) begin
                n_errors++;
                $display("FAIL reset_state: sel %0d pc %h rd %b wr %b fault %b addr %h out %h", s, o_pc, o_read, o_write, o_fault, o_addr, o_data);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_a_inst();
        do_reset();
        run_inst(24'h0007, 0, 0, 0);
        n_checks++;
        if (o_pc !== 20'd1 || o_read || o_write) begin
            n_errors++; $display("FAIL a_inst: pc %h rd %b wr %b want pc 1", o_pc, o_read, o_write);
        end
    endtask

    task automatic test_write();
        do_reset();
        run_inst(24'h0007, 0, 0, 0);
        run_inst(24'hEC10, 0, 0, 0);
        run_inst(24'hE7C8, 0, 3, 0);
        n_checks++;
        if (last_wc !== 4 || last_waddr !== 20'd7 || last_wdata !== 24'd8 || o_pc !== 20'd3) begin
            n_errors++;
            $display("FAIL write_wait: cycles %0d addr %h data %h pc %h want 4 7 8 3", last_wc, last_waddr, last_wdata, o_pc);
        end
    endtask

    task automatic test_read_jump();
        do_reset();
        run_inst(24'h0007, 0, 0, 0);
        mem[7] = 24'h008000;
        run_inst(24'hFC10, 0, 0, 0);
        n_checks++;
        if (last_rc !== 1) begin
            n_errors++; $display("FAIL read_pulse: cycles %0d want 1", last_rc);
        end
        run_inst(24'hE308, 0, 0, 0);
        n_checks++;
        if (last_wdata !== 24'h8000 || last_waddr !== 20'd7) begin
            n_errors++; $display("FAIL d_from_m: data %h addr %h want 8000 7", last_wdata, last_waddr);
        end
        run_inst(24'h0014, 0, 0, 0);
        run_inst(24'hE304, 0, 0, 0);
        n_checks++;
        if (o_pc !== 20'd20) begin
            n_errors++; $display("FAIL jlt: pc %h want 14", o_pc);
        end
        run_inst(24'hE301, 0, 0, 0);
        n_checks++;
        if (o_pc !== 20'd21) begin
            n_errors++; $display("FAIL jgt: pc %h want 15", o_pc);
        end
    endtask

    task automatic test_am_jump();
        do_reset();
        run_inst(24'h0005, 0, 0, 0);
        run_inst(24'hEDEF, 0, 1, 0);
        n_checks++;
        if (last_waddr !== 20'd5 || last_wdata !== 24'd6 || o_pc !== 20'd5) begin
            n_errors++; $display("FAIL am_jmp: addr %h data %h pc %h want 5 6 5", last_waddr, last_wdata, o_pc);
        end
        run_inst(24'hEC08, 0, 0, 0);
        n_checks++;
        if (last_waddr !== 20'd6 || last_wdata !== 24'd6) begin
            n_errors++; $display("FAIL new_a: addr %h data %h want 6 6", last_waddr, last_wdata);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run_inst(24'h7FFF, 0, 0, 0);
        run_inst(24'hEA87, 0, 0, 0);
        run_inst(24'h0000, 0, 0, 0);
        n_checks++;
        if (o_pc !== 20'd0) begin
            n_errors++; $display("FAIL pc_wrap16: pc %h want 0", o_pc);
        end
        sel = 1'b1;
        do_reset();
        run_inst(24'h0FFFFF, 0, 0, 0);
        run_inst(24'h800A87, 0, 0, 0);
        run_inst(24'h800E90, 0, 0, 0);
        n_checks++;
        if (o_pc !== 20'd0) begin
            n_errors++; $display("FAIL pc_wrap24: pc %h want 0", o_pc);
        end
        run_inst(24'h8007CA, 0, 0, 0);
        n_checks++;
        if (last_wdata !== 24'd0 || last_waddr !== 20'hFFFFF || o_pc !== 20'hFFFFF) begin
            n_errors++; $display("FAIL add_wrap24: data %h addr %h pc %h want 0 fffff fffff", last_wdata, last_waddr, o_pc);
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            do_reset();
            for (int i = 0; i < 50; i++) begin
                logic [23:0] ins;
                if ($urandom_range(0, 2) == 0)
                    ins = $urandom_range(0, 1) ? 24'($urandom_range(0, 40)) : (24'($urandom) & 24'h3FFFFF);
                else
                    ins = s ? {1'b1, 23'($urandom)} : {8'd0, 3'b111, 13'($urandom)};
                run_inst(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        run_inst(24'h0009, 0, 0, 0);
        inst = 24'hFC10; inst_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        inst_valid = 1'b0;
        n_checks++;
        if (!o_read || o_addr !== 20'd9) begin
            n_errors++; $display("FAIL abort_read_start: rd %b addr %h want 1 9", o_read, o_addr);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (o_read || o_pc !== 20'd0 || o_addr !== 20'd0) begin
            n_errors++; $display("FAIL abort_read: rd %b pc %h addr %h want 0 0 0", o_read, o_pc, o_addr);
        end
        reset = 1'b0;
        ref_a = '0; ref_d = '0; ref_pc = '0;
        inst = 24'hE308; inst_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        inst_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (!o_write) begin
            n_errors++; $display("FAIL abort_write_start: wr %b want 1", o_write);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (o_write || o_pc !== 20'd0 || o_data !== 24'd0) begin
            n_errors++; $display("FAIL abort_write: wr %b pc %h out %h want 0 0 0", o_write, o_pc, o_data);
        end
        reset = 1'b0;
        ref_a = '0; ref_d = '0; ref_pc = '0;
        run_inst(24'hE308, 0, 0, 0);
        n_checks++;
        if (last_wdata !== 24'd0 || last_waddr !== 20'd0) begin
            n_errors++; $display("FAIL abort_clean: data %h addr %h want 0 0", last_wdata, last_waddr);
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        do_reset();
        run_inst(24'h0003, 0, 0, 0);
        inst = 24'hE308; inst_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); @(negedge clk);
            inst_valid = 1'b0;
            if (o_fault) break;
            if (o_write) cnt++;
        end
        n_checks++;
        if (!o_fault || cnt !== 255 || o_write || o_read) begin
            n_errors++; $display("FAIL timeout: fault %b wait_cycles %0d wr %b want 1 255 0", o_fault, cnt, o_write);
        end
        inst = 24'h0011; inst_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mem_ack = 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        inst_valid = 1'b0; mem_ack = 1'b0;
        n_checks++;
        if (!o_fault || o_pc !== 20'd2 || o_read || o_write) begin
            n_errors++; $display("FAIL halt_hold: fault %b pc %h want 1 2", o_fault, o_pc);
        end
        do_reset();
        n_checks++;
        if (o_fault || o_pc !== 20'd0) begin
            n_errors++; $display("FAIL halt_reset: fault %b pc %h want 0 0", o_fault, o_pc);
        end
    endtask

    initial begin
        test_reset();
        test_a_inst();
        test_write();
        test_read_jump();
        test_am_jump();
        test_pc_wrap();
        test_reset_abort();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
